// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU sequencer.
// Contents:
//   DATA_W, OP_W, LEN_W : datapath, op code and length widths
//   OP_ADD, OP_PASS     : ALU op codes the sequencer knows by name
//   state_t             : sequencer state encoding
package vec_alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 5;
    localparam int LEN_W  = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b01010;
    localparam logic [OP_W-1:0] OP_PASS = 5'b00000;  // ALU passes S through

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/vec_alu_out_slice.sv
// Single-entry valid/ready register with simultaneous push/pop.
// A push always loads; a pop without a push empties the slot.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : load din this cycle (caller guarantees slot free or popping)
//   pop      : consumer takes the held entry this cycle
//   din      : entry to load
//   valid    : entry held
//   dout     : held entry
module vec_alu_out_slice
    import vec_alu_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: takes one (op, length) command, streams operand
// pairs through the external combinational ALU and presents each result
// on a registered valid/ready stream with a last flag and a done pulse.
// Optional build macro VEC_ALU_SEQ_SAT_EN: signed saturation of ADD results.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake, cmd_op, cmd_len
//   in_valid/in_ready, in_r/in_s : operand pair stream
//   alu_op, alu_r, alu_s, alu_y  : ALU drive and result
//   out_valid/out_ready, out_y   : result stream, out_last on element len-1
//   busy                         : command in progress
//   done                         : one-cycle pulse at command completion
module vec_alu_seq
    import vec_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 5,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_s,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_r,
    output logic [DATA_W-1:0] alu_s,
    input  logic [DATA_W-1:0] alu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t             state, state_nx;
    logic [OP_W-1:0]    op_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued;
    logic               zero_done;
    logic               cmd_take;
    logic               push, pop;
    logic               last_in;
    logic [DATA_W-1:0]  load_y;
    logic               slot_valid;
    logic [DATA_W:0]    slot_q;

    assign cmd_take = (state == IDLE) && cmd_valid;
    assign in_ready = (state == RUN) && (issued < len_q) && (!slot_valid || out_ready);
    assign push     = in_valid && in_ready;
    assign pop      = slot_valid && out_ready;
    assign last_in  = (issued == len_q - LEN_W'(1));

    assign alu_r  = in_r;
    assign alu_s  = in_s;
    assign alu_op = (state == RUN) ? op_q : '0;

`ifdef VEC_ALU_SEQ_SAT_EN
    // Signed overflow on ADD: operands agree in sign, result does not.
    always_comb begin
        load_y = alu_y;
        if (op_q == OP_ADD && in_r[DATA_W-1] == in_s[DATA_W-1] &&
            alu_y[DATA_W-1] != in_r[DATA_W-1]) begin
            load_y = in_r[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign load_y = alu_y;
`endif

    vec_alu_out_slice #(
        .W (DATA_W + 1)
    ) u_out (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({last_in, load_y}),
        .valid (slot_valid),
        .dout  (slot_q)
    );

    assign out_valid = slot_valid;
    assign out_y     = slot_q[DATA_W-1:0];
    assign out_last  = slot_q[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            len_q     <= '0;
            issued    <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nx;
            // Zero-length commands complete without leaving IDLE.
            zero_done <= cmd_take && (cmd_len == '0);
            if (cmd_take && cmd_len != '0) begin
                op_q   <= cmd_op;
                len_q  <= cmd_len;
                issued <= '0;
            end else if (push) begin
                issued <= issued + LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_take && cmd_len != '0) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pop && out_last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign done = (state == DONE) || zero_done;

endmodule

// File: tb/tb_vec_alu_seq.sv
module tb_vec_alu_seq;
    import vec_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [4:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic        in_valid, in_ready;
    logic [15:0] in_r, in_s;
    logic [4:0]  alu_op;
    logic [15:0] alu_r, alu_s, alu_y;
    logic        out_valid, out_ready;
    logic [15:0] out_y;
    logic        out_last, busy, done;

    int checks = 0;
    int errors = 0;
    logic [15:0] pr [64];
    logic [15:0] ps [64];

    always #5 clk = ~clk;

    vec_alu_seq #(.DATA_W(16), .OP_W(5), .LEN_W(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_s(in_s),
        .alu_op(alu_op), .alu_r(alu_r), .alu_s(alu_s), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_last(out_last),
        .busy(busy), .done(done)
    );

    // Behavioural stand-in for the shared ALU.
    function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] r, input logic [15:0] s);
        case (op)
            5'b01010: return r + s;
            5'b00000: return s;
            5'b00001: return r & s;
            5'b00010: return r | s;
            5'b00011: return r ^ s;
            5'b01011: return r - s;
            default:  return ~r;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_op, alu_r, alu_s);

    // Expected element result: ALU result, saturated for ADD when enabled.
    function automatic logic [15:0] exp_fn(input logic [4:0] op, input logic [15:0] r, input logic [15:0] s);
        logic [15:0] y;
        y = alu_fn(op, r, s);
`ifdef VEC_ALU_SEQ_SAT_EN
        if (op == 5'b01010) begin
            int sum;
            sum = int'($signed(r)) + int'($signed(s));
            if (sum > 32767)  y = 16'h7FFF;
            if (sum < -32768) y = 16'h8000;
        end
`endif
        return y;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            pr[i] = 16'($urandom);
            ps[i] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 0; cmd_op = '0; cmd_len = '0;
        in_valid = 0; in_r = '0; in_s = '0; out_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_y !== 16'h0) begin errors++; $display("FAIL reset_out_y got %h want 0000", out_y); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        checks++; if (alu_op !== 5'h0) begin errors++; $display("FAIL reset_alu_op got %h want 00", alu_op); end
        @(negedge clk); rst = 1'b0;
    endtask

    // Run one vector command against a queue model of the result stream.
    task automatic run_vec(input logic [4:0] op, input int len, input int stall_pct, input int hold_n,
                           input bit rnd_valid, input bit pre_acc, input bit chain,
                           input logic [4:0] nop, input int nlen);
        int issued = 0, popped = 0, cyc = 0, idx, hold = hold_n;
        logic [15:0] q [$];
        bit had, exp_rdy;
        if (!pre_acc) begin
            @(negedge clk);
            cmd_valid = 1; cmd_op = op; cmd_len = 6'(len);
            #1;
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_accept got %b want 1", cmd_ready); end
            @(posedge clk); @(negedge clk);
            cmd_valid = 0;
        end
        while (popped < len && cyc < 40 * len + 50) begin
            cyc++;
            idx = (issued < len) ? issued : 0;
            in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            in_r = pr[idx]; in_s = ps[idx];
            #1;
            had = (q.size() != 0);
            if (had && hold > 0) begin out_ready = 0; hold--; end
            else out_ready = ($urandom_range(0, 99) >= stall_pct);
            #1;
            exp_rdy = (issued < len) && (!had || out_ready);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL run_in_ready got %b want %b", in_ready, exp_rdy); end
            checks++; if (out_valid !== had) begin errors++; $display("FAIL run_out_valid got %b want %b", out_valid, had); end
            checks++; if (busy !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL run_status busy/done/cmd_ready got %b%b%b want 100", busy, done, cmd_ready); end
            checks++; if (alu_op !== op) begin errors++; $display("FAIL run_alu_op got %h want %h", alu_op, op); end
            if (had) begin
                checks++; if (out_y !== q[0]) begin errors++; $display("FAIL run_out_y elem %0d got %h want %h", popped, out_y, q[0]); end
                checks++; if (out_last !== (popped == len - 1)) begin errors++; $display("FAIL run_out_last elem %0d got %b want %b", popped, out_last, popped == len - 1); end
                if (out_ready) begin void'(q.pop_front()); popped++; end
            end
            if (in_valid && exp_rdy) begin q.push_back(exp_fn(op, pr[issued], ps[issued])); issued++; end
            @(negedge clk);
        end
        checks++; if (popped != len) begin errors++; $display("FAIL run_timeout popped %0d want %0d", popped, len); end
        in_valid = 0;
        if (chain) begin cmd_valid = 1; cmd_op = nop; cmd_len = 6'(nlen); end
        #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL done_cycle done/busy/cmd_ready got %b%b%b want 100", done, busy, cmd_ready); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || alu_op !== 5'h0) begin errors++; $display("FAIL done_idle_outputs got %b%b%h want 0 0 00", out_valid, in_ready, alu_op); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL after_done done/busy/cmd_ready got %b%b%b want 001", done, busy, cmd_ready); end
        if (chain) begin @(posedge clk); @(negedge clk); cmd_valid = 0; end
    endtask

    task automatic test_add_directed();
        pr[0] = 16'h0001; ps[0] = 16'h0002;
        pr[1] = 16'h0003; ps[1] = 16'h0004;
        pr[2] = 16'hFFFF; ps[2] = 16'h0001;
        run_vec(OP_ADD, 3, 0, 0, 0, 0, 0, 5'h0, 0);
    endtask

    task automatic test_stall();
        fill_rand();
        run_vec(OP_PASS, 4, 0, 3, 0, 0, 0, 5'h0, 0);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        cmd_valid = 1; cmd_op = OP_ADD; cmd_len = '0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_accept got %b want 1", cmd_ready); end
        @(negedge clk); cmd_valid = 0; #1;
        checks++; if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done done/cmd_ready/busy got %b%b%b want 110", done, cmd_ready, busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out_valid got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (done !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_after done/out_valid/cmd_ready got %b%b%b want 001", done, out_valid, cmd_ready); end
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        @(negedge clk);
        cmd_valid = 1; cmd_op = 5'b00011; cmd_len = 6'd5;
        @(negedge clk); cmd_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_r = pr[i]; in_s = ps[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready elem %0d got %b want 1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 0; #1;
        checks++; if (out_valid !== 1'b1 || out_y !== exp_fn(5'b00011, pr[1], ps[1])) begin errors++; $display("FAIL mid_held got %b %h want 1 %h", out_valid, out_y, exp_fn(5'b00011, pr[1], ps[1])); end
        rst = 1; #1;
        checks++; if (out_valid !== 1'b0 || out_y !== 16'h0 || out_last !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b %h %b want 0 0000 0", out_valid, out_y, out_last); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0 || alu_op !== 5'h0) begin errors++; $display("FAIL mid_rst_status got %b%b%b%b %h want 0010 00", busy, done, cmd_ready, in_ready, alu_op); end
        @(negedge clk); rst = 0;
        run_vec(5'b01011, 1, 0, 0, 0, 0, 0, 5'h0, 0);
    endtask

    task automatic test_sat();
        pr[0] = 16'h7FFF; ps[0] = 16'h0001;
        pr[1] = 16'h8000; ps[1] = 16'hFFFF;
        run_vec(OP_ADD, 2, 0, 0, 0, 0, 0, 5'h0, 0);
    endtask

    task automatic test_back_to_back();
        fill_rand();
        run_vec(5'b00011, 3, 0, 0, 0, 0, 1, OP_ADD, 2);
        run_vec(OP_ADD, 2, 0, 0, 0, 1, 0, 5'h0, 0);
    endtask

    task automatic test_random();
        logic [4:0] ops [6];
        ops[0] = OP_ADD; ops[1] = OP_PASS; ops[2] = 5'b00001;
        ops[3] = 5'b00010; ops[4] = 5'b00011; ops[5] = 5'b01011;
        for (int n = 0; n < 8; n++) begin
            fill_rand();
            run_vec(ops[$urandom_range(0, 5)], $urandom_range(1, 20), 30, 0, 1, 0, 0, 5'h0, 0);
        end
        fill_rand();
        run_vec(OP_ADD, 63, 20, 2, 1, 0, 0, 5'h0, 0);
    endtask

    initial begin
        test_reset();
        test_add_directed();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_sat();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Sequences the shared 16-bit vector ALU over an N-element vector operation.
- Accepts one command (op, length), then streams element pairs (R, S) through the ALU.
- Registers each result and emits it on a valid/ready result stream, with a last-element flag and a completion pulse.
- Sits between the vector load/issue logic and the ALU; it is the only driver of the ALU operand and op inputs.

Parameters:
- DATA_W, 16, operand and result width; must match the ALU.
- OP_W, 5, ALU op code width.
- LEN_W, 6, command length width; the maximum vector length is 2^LEN_W - 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command can be taken
- cmd_op  in  OP_W  ALU op for the whole vector
- cmd_len  in  LEN_W  element count
- in_valid  in  1  element pair offered
- in_ready  out  1  element pair accepted this cycle
- in_r  in  DATA_W  R operand
- in_s  in  DATA_W  S operand
- alu_op  out  OP_W  to ALU ALU_Op
- alu_r  out  DATA_W  to ALU R
- alu_s  out  DATA_W  to ALU S
- alu_y  in  DATA_W  from ALU Y (combinational)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_y  out  DATA_W  registered result
- out_last  out  1  result is element len-1
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, cmd_ready=1, in_ready=0, out_valid=0, out_y=0, out_last=0, busy=0, done=0, op register=0, counters=0.
  - A reset asserted mid-command abandons the command. Any held result is dropped and not presented.
- States:
  - IDLE: cmd_ready=1, busy=0.
    - On cmd_valid with cmd_len>0: latch op and len, clear the issued and retired counters, go to RUN.
    - On cmd_valid with cmd_len==0: the command is accepted, done pulses the next cycle, no results are produced, and the state stays IDLE.
  - RUN: busy=1, cmd_ready=0.
    - in_ready = (issued<len) && (!out_valid || out_ready). This is a single-entry output register with pass-through on pop.
    - On in_valid && in_ready: load out_y from alu_y, set out_valid=1, set out_last = (issued==len-1), increment issued.
    - On out_valid && out_ready with no new load the same cycle: out_valid=0.
    - A pop and a load in the same cycle both happen; out_valid stays 1 with the new data.
    - When out_valid && out_ready && out_last: go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0, then go to IDLE. A back-to-back command can be taken one cycle after done.
- ALU drive:
  - alu_r = in_r and alu_s = in_s, combinationally, in all states.
  - alu_op = latched op in RUN, 0 otherwise.
- Latency: one cycle from input acceptance to out_valid. Throughput is one element per cycle when out_ready is held high.
- Outputs hold stable while out_valid && !out_ready.
- in_valid while not in RUN, or after issued==len, is ignored.
- Widths: the ALU result is taken modulo 2^DATA_W; no carry out is reported.

Optional Feature:
- Macro: VEC_ALU_SEQ_SAT_EN.
- Defined: when the latched op is 5'b01010 (ADD), the loaded result saturates as signed.
  - Both operands have the same sign and alu_y's sign differs: load 16'h7FFF if the operands were positive, 16'h8000 if negative.
  - Other ops are unaffected.
- Undefined: alu_y is loaded unmodified (wrap).

Decomposition:
- Package vec_alu_pkg holds:
  - DATA_W and OP_W constants.
  - Op codes: OP_ADD=5'b01010; OP_PASS=5'b00000, selecting S pass-through.
  - State enum {IDLE, RUN, DONE}.
- One natural sub-module: vec_alu_out_slice, the single-entry valid/ready result register with simultaneous push/pop, reused for out_y/out_last.

Test Plan:
- cmd op=01010, len=3; pairs (1,2),(3,4),(0xFFFF,1); out_ready=1 -> out_y 3, 7, 0 on consecutive cycles; out_last only on the third; done pulses one cycle after the third pop.
- len=4, op=OP_PASS, out_ready low for 3 cycles after the first result -> in_ready drops, out_y holds S of the first pair, no element lost or duplicated; 4 results in order.
- cmd_len=0 -> cmd_ready stays 1, done pulses once, out_valid never rises.
- rst asserted after 2 of 5 elements -> all outputs at reset values immediately; a new len=1 command afterwards completes normally.
- With VEC_ALU_SEQ_SAT_EN, ADD (0x7FFF,1) -> 0x7FFF and (0x8000,0xFFFF) -> 0x8000; without the macro -> 0x8000 and 0x7FFF.
- Two back-to-back commands with cmd_valid held -> the second is accepted in the cycle after done; busy is low for exactly the DONE and IDLE cycles.
